// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared register-index, data-word and writeback-entry types
// Contents:
//   reg_idx_t  : 5-bit architectural register index
//   word_t     : 32-bit data word
//   wb_entry_t : buffered writeback result {rd, data}
//   wb_src_e   : writeback source selected for the next register-file write
package cpu_types;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO buffering slow-port writeback results
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears pointers/count)
//   push        : enqueue push_data (accepted when not full, or full with a pop)
//   push_data   : element to enqueue
//   pop         : dequeue the head element (ignored when empty)
//   head        : oldest element, valid whenever empty is 0
//   count       : number of stored elements, 0..DEPTH
//   full, empty : occupancy flags
module wb_fifo #(
  parameter int  DEPTH  = 2,
  parameter type elem_t = logic [36:0],
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  elem_t         push_data,
  input  logic          pop,
  output elem_t         head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  elem_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write port arbiter with slow-result buffer and scoreboard
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   alu_valid, alu_rd, alu_data    : single-cycle ALU result for this cycle
//   wb_stall                       : ALU result not taken this cycle, upstream holds it
//   lsu_valid, lsu_rd, lsu_data    : long-latency result offer (transfer on valid && ready)
//   lsu_ready                      : slow-result buffer can accept this cycle
//   issue_valid, issue_rd          : long-latency op issued, marks issue_rd pending
//   busy                           : one pending bit per architectural register
//   a3, we3, wd3                   : registered register-file write port
module regfile_writeback
  import cpu_types::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        wb_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic [4:0]  a3,
  output logic        we3,
  output logic [31:0] wd3
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0]  SC_ONE     = 1;

  wb_entry_t        lsu_entry;
  wb_entry_t        fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic [SC_W-1:0]  starve_cnt;
  logic             forced_drain;
  wb_src_e          sel;
  wb_entry_t        sel_entry;
  logic [31:0]      busy_next;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (wb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lsu_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Source selection: a starved FIFO beats the ALU, otherwise the ALU beats
  // the FIFO, otherwise the FIFO drains in idle ALU cycles.
  always_comb begin
    forced_drain = !fifo_empty && (starve_cnt == STARVE_MAX);
    sel          = SRC_IDLE;
    sel_entry    = '0;
    if (rst) begin
      sel = SRC_IDLE;
    end else if (forced_drain) begin
      sel       = SRC_FIFO;
      sel_entry = fifo_head;
    end else if (alu_valid) begin
      sel       = SRC_ALU;
      sel_entry = '{rd: alu_rd, data: alu_data};
    end else if (!fifo_empty) begin
      sel       = SRC_FIFO;
      sel_entry = fifo_head;
    end
  end

  assign fifo_pop = (sel == SRC_FIFO);
  assign wb_stall = !rst && alu_valid && forced_drain;

  // A full buffer still accepts when its head is written this same cycle.
  assign lsu_ready = !rst && ((fifo_count < DEPTH_CNT) || (fifo_full && fifo_pop));
  assign fifo_push = lsu_valid && lsu_ready;

  // Write port: an entry aimed at x0 is consumed but never asserts we3.
  // a3/wd3 keep their last value on idle cycles; only we3 qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= (sel != SRC_IDLE) && (sel_entry.rd != '0);
      if (sel != SRC_IDLE) begin
        a3  <= sel_entry.rd;
        wd3 <= sel_entry.data;
      end
    end
  end

  // Counts consecutive ALU wins over a waiting FIFO entry; any drain or an
  // empty buffer restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if ((sel == SRC_ALU) && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SC_ONE;
    end
  end

  // Scoreboard: the clear is applied first so that a same-cycle issue to the
  // same register leaves it pending. ALU writes never touch it.
  always_comb begin
    busy_next = busy;
    if (fifo_pop && (fifo_head.rd != '0)) busy_next[fifo_head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0))  busy_next[issue_rd]     = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
module tb_regfile_writeback;
  import cpu_types::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst, alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        wb_stall, lsu_ready, we3;
  logic [31:0] busy, wd3;
  logic [4:0]  a3;

  regfile_writeback #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .wb_stall(wb_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy), .a3(a3), .we3(we3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic        e_stall, e_ready, e_we3, chk_aw;
    logic [4:0]  e_a3;
    logic [31:0] e_wd3, e_busy;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 0;
  vec_t tbl[$];

  // Reference model: a queue of pending slow results plus plain bookkeeping.
  wb_entry_t   mq[$];
  logic [31:0] m_busy = '0;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_a = '0;
  logic [31:0] m_d = '0;

  function automatic vec_t row(input logic r, av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic iv, input logic [4:0] ird,
                               input logic es, er, ewe, caw, input logic [4:0] ea,
                               input logic [31:0] ed, eb);
    vec_t v;
    v.rst = r; v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.e_stall = es; v.e_ready = er; v.e_we3 = ewe;
    v.chk_aw = caw; v.e_a3 = ea; v.e_wd3 = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input vec_t v, output logic e_stall, output logic e_ready);
    bit        has, forced, pop;
    wb_entry_t h;
    if (v.rst) begin
      e_stall = 1'b0; e_ready = 1'b0;
      mq.delete(); m_busy = '0; m_starve = 0;
      m_we = 1'b0; m_a = '0; m_d = '0;
    end else begin
      has     = mq.size() > 0;
      forced  = has && (m_starve == LIMIT);
      pop     = forced || (!v.av && has);
      e_stall = v.av && forced;
      e_ready = (mq.size() < DEPTH) || pop;
      h       = '0;
      if (pop) begin
        h = mq.pop_front();
        m_we = (h.rd != 0); m_a = h.rd; m_d = h.data;
      end else if (v.av) begin
        m_we = (v.ard != 0); m_a = v.ard; m_d = v.ad;
      end else begin
        m_we = 1'b0;
      end
      if (pop || !has)  m_starve = 0;
      else if (v.av)    m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      if (pop && h.rd != 0)        m_busy[h.rd]  = 1'b0;
      if (v.iv && v.ird != 0)      m_busy[v.ird] = 1'b1;
      if (v.lv && e_ready) mq.push_back('{rd: v.lrd, data: v.ld});
    end
  endtask

  task automatic apply(input vec_t v, input bit use_exp, input int idx);
    logic        es, er, pwe;
    logic [4:0]  pa;
    logic [31:0] pd, pb;
    @(negedge clk);
    rst = v.rst; alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    issue_valid = v.iv; issue_rd = v.ird;
    #1;
    pwe = m_we; pa = m_a; pd = m_d; pb = m_busy;
    model_step(v, es, er);
    if (checking) begin
      check($sformatf("model stall c%0d", idx), wb_stall, es);
      check($sformatf("model ready c%0d", idx), lsu_ready, er);
      check($sformatf("model we3 c%0d", idx), we3, pwe);
      if (pwe) begin
        check($sformatf("model a3 c%0d", idx), a3, pa);
        check($sformatf("model wd3 c%0d", idx), wd3, pd);
      end
      check($sformatf("model busy c%0d", idx), busy, pb);
    end
    if (use_exp) begin
      check($sformatf("T%0d stall", idx), wb_stall, v.e_stall);
      check($sformatf("T%0d ready", idx), lsu_ready, v.e_ready);
      check($sformatf("T%0d we3", idx), we3, v.e_we3);
      if (v.chk_aw) begin
        check($sformatf("T%0d a3", idx), a3, v.e_a3);
        check($sformatf("T%0d wd3", idx), wd3, v.e_wd3);
      end
      check($sformatf("T%0d busy", idx), busy, v.e_busy);
    end
  endtask

  initial begin
    vec_t v;
    //          rst av ard  ad            lv lrd ld        iv ird  st rd we ck a3  wd3           busy
    tbl.push_back(row(1, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 0, 0, 1, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 1, 5,  32'hDEADBEEF, 0, 0, 32'h0,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 5,  32'hDEADBEEF, 32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 7,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        1, 7, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h80));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h80));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 7,  32'h1234,     32'h0));
    tbl.push_back(row(0, 1, 10, 32'hA0,       1, 2, 32'h22, 0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 1, 11, 32'hB1,       0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 10, 32'hA0,       32'h0));
    tbl.push_back(row(0, 1, 12, 32'hB2,       0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 11, 32'hB1,       32'h0));
    tbl.push_back(row(0, 1, 13, 32'hB3,       0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 12, 32'hB2,       32'h0));
    tbl.push_back(row(0, 1, 14, 32'hB4,       0, 0, 32'h0,  0, 0,  1, 1, 1, 1, 13, 32'hB3,       32'h0));
    tbl.push_back(row(0, 1, 14, 32'hB4,       0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 2,  32'h22,       32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 14, 32'hB4,       32'h0));
    tbl.push_back(row(0, 1, 20, 32'hC0,       1, 3, 32'h33, 0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 1, 21, 32'hC1,       1, 4, 32'h44, 0, 0,  0, 1, 1, 1, 20, 32'hC0,       32'h0));
    tbl.push_back(row(0, 1, 22, 32'hC2,       1, 5, 32'h55, 0, 0,  0, 0, 1, 1, 21, 32'hC1,       32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        1, 5, 32'h55, 0, 0,  0, 1, 1, 1, 22, 32'hC2,       32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 3,  32'h33,       32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 4,  32'h44,       32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 5,  32'h55,       32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        1, 0, 32'h99, 0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 9,  0, 1, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        1, 9, 32'h90, 0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h200));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  1, 9,  0, 1, 0, 0, 0,  32'h0,        32'h200));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 1, 1, 9,  32'h90,       32'h200));
    tbl.push_back(row(0, 1, 1,  32'h1,        1, 6, 32'h66, 0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h200));
    tbl.push_back(row(0, 1, 1,  32'h2,        1, 7, 32'h77, 0, 0,  0, 1, 1, 1, 1,  32'h1,        32'h200));
    tbl.push_back(row(1, 1, 1,  32'h3,        1, 8, 32'h88, 0, 0,  0, 0, 1, 1, 1,  32'h2,        32'h200));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 0, 1, 0,  32'h0,        32'h0));
    tbl.push_back(row(0, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0));

    // Two unchecked reset cycles bring the DUT out of power-up X.
    checking = 0;
    for (int i = 0; i < 2; i++) apply(tbl[0], 1'b0, -1);
    checking = 1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1, i);

    // Random traffic against the queue model; rd kept small to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      v = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst = ($urandom_range(79) == 0);
      v.av  = ($urandom_range(99) < 55);
      v.ard = 5'($urandom_range(15));
      v.ad  = $urandom;
      v.lv  = ($urandom_range(99) < 50);
      v.lrd = 5'($urandom_range(15));
      v.ld  = $urandom;
      v.iv  = ($urandom_range(99) < 30);
      v.ird = 5'($urandom_range(15));
      apply(v, 1'b0, 1000 + n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
